// File: rtl/lu_pkg.sv
// lu_pkg
//   Shared types and constants for the complex LU engine and its row store.
//   row_t       : one matrix row, SIZE complex elements, each {imag, real}
//   lrs_state_t : row store control states
//   ONE_C       : complex 1.0 + 0.0i in IEEE-754 double layout
package lu_pkg;

  localparam int LU_SIZE = 16;
  localparam int LU_DW   = 64;

  typedef logic [LU_SIZE-1:0][2*LU_DW-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    KICK,
    RUN
  } lrs_state_t;

  localparam logic [2*LU_DW-1:0] ONE_C = {64'b0, 64'h3ff0000000000000};

endpackage

// File: rtl/lu_row_mem.sv
// lu_row_mem
//   SIZE x row register file; one synchronous write port, one combinational
//   read port, no reset (contents survive reset and flush).
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write row address
//   wdata_i : write row data
//   raddr_i : read row address
//   rdata_o : read row data (combinational)
module lu_row_mem #(
  parameter int SIZE = 16,
  parameter int DW   = 64,
  localparam int AW  = $clog2(SIZE),
  localparam int RW  = SIZE * 2 * DW
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [RW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [RW-1:0] rdata_o
);

  logic [RW-1:0] mem_q [SIZE];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lu_row_store.sv
// lu_row_store
//   Row-addressed working store in front of the LU engine. Collects an NxN
//   complex matrix row by row, pulses start, serves row reads with one cycle
//   latency, accepts in-place row write-backs and flags completion.
//   clk_i / rst_ni         : clock, synchronous active-low reset
//   flush_i                : abort to IDLE, memory kept
//   load_row_i/_valid_i    : incoming matrix rows, handshake with load_ready_o
//   start_o                : one-cycle start pulse to the engine
//   lu_busy_i              : engine busy
//   rd_addr_i/_vld_i       : engine row read request
//   rd_row_o/_valid_o/_addr_o : returned row, sticky until the next request
//   wr_row_i/_valid_i/_addr_i : engine row write-back, handshake with wr_ready_o
//   done_o                 : one-cycle pulse when the engine has finished
import lu_pkg::*;

module lu_row_store #(
  parameter int SIZE = LU_SIZE,
  parameter int DW   = LU_DW,
  localparam int AW  = $clog2(SIZE),
  localparam int RW  = SIZE * 2 * DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic [RW-1:0] load_row_i,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  output logic          start_o,
  input  logic          lu_busy_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          rd_addr_vld_i,
  output logic [RW-1:0] rd_row_o,
  output logic          rd_valid_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [RW-1:0] wr_row_i,
  input  logic          wr_valid_i,
  input  logic [AW-1:0] wr_addr_i,
  output logic          wr_ready_o,
  output logic          done_o
);

  lrs_state_t    state_q, state_d;
  logic [AW-1:0] loadCnt_q, loadCnt_d;
  logic          seenBusy_q, seenBusy_d;
  logic [RW-1:0] rdRow_q, rdRow_d;
  logic [AW-1:0] rdAddr_q, rdAddr_d;
  logic          rdValid_q, rdValid_d;

  logic          live;
  logic          loadFire, wrFire, finish;
  logic          memWe;
  logic [AW-1:0] memWaddr;
  logic [RW-1:0] memWdata, memRdata;

  // Reset and flush suppress every handshake and pulse in the cycle they occur.
  assign live         = rst_ni & ~flush_i;
  assign load_ready_o = live & ((state_q == IDLE) | (state_q == LOAD));
  assign wr_ready_o   = live & (state_q == RUN);
  assign start_o      = live & (state_q == KICK);
  assign finish       = (state_q == RUN) & seenBusy_q & ~lu_busy_i;
  assign done_o       = live & finish;
  assign loadFire     = load_valid_i & load_ready_o;
  assign wrFire       = wr_valid_i & wr_ready_o;

  assign rd_row_o   = rdRow_q;
  assign rd_addr_o  = rdAddr_q;
  assign rd_valid_o = rdValid_q & (state_q == RUN);

  // Loads and engine write-backs never overlap (different states), so one port serves both.
  assign memWe    = loadFire | wrFire;
  assign memWaddr = wrFire ? wr_addr_i : loadCnt_q;
  assign memWdata = wrFire ? wr_row_i : load_row_i;

  lu_row_mem #(
    .SIZE(SIZE),
    .DW  (DW)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (memWe),
    .waddr_i(memWaddr),
    .wdata_i(memWdata),
    .raddr_i(rd_addr_i),
    .rdata_o(memRdata)
  );

  always_comb begin
    state_d    = state_q;
    loadCnt_d  = loadCnt_q;
    seenBusy_d = seenBusy_q;
    rdRow_d    = rdRow_q;
    rdAddr_d   = rdAddr_q;
    rdValid_d  = rdValid_q;

    if (loadFire) begin
      loadCnt_d = loadCnt_q + AW'(1);
    end

    case (state_q)
      IDLE: begin
        if (loadFire) state_d = LOAD;
      end
      LOAD: begin
        if (loadFire && (loadCnt_q == AW'(SIZE - 1))) state_d = KICK;
      end
      KICK: begin
        state_d = RUN;
      end
      RUN: begin
        if (lu_busy_i) seenBusy_d = 1'b1;
        if (finish) begin
          state_d    = IDLE;
          seenBusy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // New read: write-first forwarding. No read: keep the held row coherent with writes.
    if ((state_q == RUN) && rd_addr_vld_i) begin
      rdAddr_d  = rd_addr_i;
      rdValid_d = 1'b1;
      rdRow_d   = (wrFire && (wr_addr_i == rd_addr_i)) ? wr_row_i : memRdata;
    end else if (wrFire && (wr_addr_i == rdAddr_q)) begin
      rdRow_d = wr_row_i;
    end

    if (state_q != RUN) begin
      rdValid_d = 1'b0;
    end
  end

  // Reset clears the read register too; flush leaves the returned row/address as they were.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      loadCnt_q  <= '0;
      seenBusy_q <= 1'b0;
      rdValid_q  <= 1'b0;
      rdAddr_q   <= '0;
      rdRow_q    <= '0;
    end else if (flush_i) begin
      state_q    <= IDLE;
      loadCnt_q  <= '0;
      seenBusy_q <= 1'b0;
      rdValid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      loadCnt_q  <= loadCnt_d;
      seenBusy_q <= seenBusy_d;
      rdValid_q  <= rdValid_d;
      rdAddr_q   <= rdAddr_d;
      rdRow_q    <= rdRow_d;
    end
  end

endmodule

// File: tb/tb_lu_row_store.sv
// tb_lu_row_store
//   Directed bench for lu_row_store with SIZE=4, DW=64. The bench plays the
//   loader and the LU engine, then checks the factorised matrix stored back.
module tb_lu_row_store;

  localparam int SIZE = 4;
  localparam int DW   = 64;
  localparam int AW   = 2;
  localparam int RW   = SIZE * 2 * DW;

  typedef logic [SIZE-1:0][2*DW-1:0] rowT;

  logic          clk = 1'b0;
  logic          rstN;
  logic          flush;
  logic [RW-1:0] loadRow;
  logic          loadValid;
  logic          loadReady;
  logic          startO;
  logic          luBusy;
  logic [AW-1:0] rdAddrI;
  logic          rdAddrVld;
  logic [RW-1:0] rdRowO;
  logic          rdValidO;
  logic [AW-1:0] rdAddrO;
  logic [RW-1:0] wrRow;
  logic          wrValid;
  logic [AW-1:0] wrAddr;
  logic          wrReady;
  logic          doneO;

  int cmpCnt = 0;
  int errCnt = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  lu_row_store #(
    .SIZE(SIZE),
    .DW  (DW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .flush_i      (flush),
    .load_row_i   (loadRow),
    .load_valid_i (loadValid),
    .load_ready_o (loadReady),
    .start_o      (startO),
    .lu_busy_i    (luBusy),
    .rd_addr_i    (rdAddrI),
    .rd_addr_vld_i(rdAddrVld),
    .rd_row_o     (rdRowO),
    .rd_valid_o   (rdValidO),
    .rd_addr_o    (rdAddrO),
    .wr_row_i     (wrRow),
    .wr_valid_i   (wrValid),
    .wr_addr_i    (wrAddr),
    .wr_ready_o   (wrReady),
    .done_o       (doneO)
  );

  // Watchdog so the run always ends even if the sequence gets stuck.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Let the current input values be sampled over n clock edges; outputs settle 1 unit later.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One comparison: counts it, and on a miss counts and reports it.
  task automatic checkOutput(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic rowT mkRow(input real e0, input real e1, input real e2, input real e3);
    rowT r;
    r[0] = {64'b0, $realtobits(e0)};
    r[1] = {64'b0, $realtobits(e1)};
    r[2] = {64'b0, $realtobits(e2)};
    r[3] = {64'b0, $realtobits(e3)};
    return r;
  endfunction

  function automatic real elem(input rowT r, input int j);
    return $bitstoreal(r[j][DW-1:0]);
  endfunction

  // Adding +0.0 folds a -0.0 into +0.0 so exact values compare bitwise.
  function automatic logic [63:0] canon(input real x);
    return $realtobits(x + 0.0);
  endfunction

  task automatic loadRows(input rowT r0, input rowT r1, input rowT r2, input rowT r3);
    rowT rows [SIZE];
    rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
    for (int i = 0; i < SIZE; i++) begin
      loadRow   = rows[i];
      loadValid = 1'b1;
      applyStimulus(1);
    end
    loadValid = 1'b0;
  endtask

  task automatic readRow(input int addr, output rowT r);
    rdAddrI   = AW'(addr);
    rdAddrVld = 1'b1;
    applyStimulus(1);
    rdAddrVld = 1'b0;
    r = rdRowO;
    checkOutput($sformatf("rd_addr_o after read %0d", addr), rdAddrO, RW'(addr));
    checkOutput($sformatf("rd_valid_o after read %0d", addr), rdValidO, 1);
  endtask

  task automatic writeRow(input int addr, input rowT r);
    wrAddr  = AW'(addr);
    wrRow   = r;
    wrValid = 1'b1;
    #1;
    checkOutput($sformatf("wr_ready_o write %0d", addr), wrReady, 1);
    applyStimulus(1);
    wrValid = 1'b0;
  endtask

  rowT idR [SIZE];
  rowT matA [SIZE];
  rowT luExp [SIZE];
  rowT gRow, xRow, yRow, zRow, rowK, rowI, rowGot;
  rowT luGot [SIZE];
  real lval, piv, lij, uij, acc;

  initial begin
    idR[0] = mkRow(1, 0, 0, 0);
    idR[1] = mkRow(0, 1, 0, 0);
    idR[2] = mkRow(0, 0, 1, 0);
    idR[3] = mkRow(0, 0, 0, 1);
    matA[0] = mkRow(4, 3, 0, 0);
    matA[1] = mkRow(6, 3, 0, 0);
    matA[2] = mkRow(0, 0, 2, 1);
    matA[3] = mkRow(0, 0, 1, 3);
    luExp[0] = mkRow(4,   3,    0,   0);
    luExp[1] = mkRow(1.5, -1.5, 0,   0);
    luExp[2] = mkRow(0,   0,    2,   1);
    luExp[3] = mkRow(0,   0,    0.5, 2.5);
    gRow = mkRow(9, 9, 9, 9);
    xRow = mkRow(7, 8, 9, 10);
    yRow = mkRow(-1, -2, -3, -4);
    zRow = mkRow(5, 5, 5, 5);

    rstN = 1'b0; flush = 1'b0; loadRow = '0; loadValid = 1'b0; luBusy = 1'b0;
    rdAddrI = '0; rdAddrVld = 1'b0; wrRow = '0; wrValid = 1'b0; wrAddr = '0;

    // Reset state.
    applyStimulus(2);
    rstN = 1'b1;
    #1;
    checkOutput("reset start_o", startO, 0);
    checkOutput("reset done_o", doneO, 0);
    checkOutput("reset rd_valid_o", rdValidO, 0);
    checkOutput("reset wr_ready_o", wrReady, 0);
    checkOutput("reset rd_addr_o", rdAddrO, 0);
    checkOutput("reset rd_row_o", rdRowO, 0);
    checkOutput("reset load_ready_o", loadReady, 1);

    // Reset in the middle of a load: the next load must land in row 0 again.
    loadRow = gRow; loadValid = 1'b1;
    applyStimulus(2);
    loadValid = 1'b0;
    rstN = 1'b0;
    applyStimulus(1);
    rstN = 1'b1;
    #1;
    checkOutput("mid-load reset load_ready_o", loadReady, 1);
    checkOutput("mid-load reset start_o", startO, 0);

    // Identity load: start pulses exactly once, the cycle after the 4th handshake.
    for (int i = 0; i < SIZE; i++) begin
      loadRow = idR[i]; loadValid = 1'b1;
      applyStimulus(1);
      checkOutput($sformatf("start_o after load %0d", i), startO, (i == SIZE - 1) ? 1 : 0);
    end
    loadValid = 1'b0;
    applyStimulus(1);
    checkOutput("start_o second cycle", startO, 0);
    checkOutput("RUN wr_ready_o", wrReady, 1);
    checkOutput("RUN rd_valid_o before read", rdValidO, 0);
    applyStimulus(2);
    checkOutput("RUN no busy yet done_o", doneO, 0);
    checkOutput("RUN no busy yet wr_ready_o", wrReady, 1);

    // Reads and holding.
    luBusy = 1'b1;
    applyStimulus(1);
    readRow(2, rowGot);
    checkOutput("read row 2", rowGot, idR[2]);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1);
      checkOutput($sformatf("hold rd_addr_o cyc %0d", c), rdAddrO, 2);
      checkOutput($sformatf("hold rd_row_o cyc %0d", c), rdRowO, idR[2]);
      checkOutput($sformatf("hold rd_valid_o cyc %0d", c), rdValidO, 1);
    end
    readRow(0, rowGot);
    checkOutput("read row 0 after mid-load reset", rowGot, idR[0]);

    // Same-cycle read and write to row 1: write-first forwarding.
    rdAddrI = 2'd1; rdAddrVld = 1'b1;
    wrAddr = 2'd1; wrRow = xRow; wrValid = 1'b1;
    applyStimulus(1);
    rdAddrVld = 1'b0; wrValid = 1'b0;
    checkOutput("forward rd_row_o", rdRowO, xRow);
    checkOutput("forward rd_addr_o", rdAddrO, 1);

    // Holding row 3, then a write to row 3 refreshes the held row.
    readRow(3, rowGot);
    checkOutput("read row 3", rowGot, idR[3]);
    writeRow(3, yRow);
    checkOutput("coherent rd_row_o", rdRowO, yRow);
    checkOutput("coherent rd_valid_o", rdValidO, 1);
    checkOutput("coherent rd_addr_o", rdAddrO, 3);

    // Busy for 10 cycles, then drop: done pulse and back to IDLE.
    applyStimulus(10);
    checkOutput("busy done_o", doneO, 0);
    luBusy = 1'b0;
    #1;
    checkOutput("done_o pulse", doneO, 1);
    applyStimulus(1);
    checkOutput("after done done_o", doneO, 0);
    checkOutput("after done load_ready_o", loadReady, 1);
    checkOutput("after done rd_valid_o", rdValidO, 0);
    checkOutput("after done wr_ready_o", wrReady, 0);

    // Full factorisation loop, the bench acting as the LU engine.
    loadRows(matA[0], matA[1], matA[2], matA[3]);
    applyStimulus(1);
    luBusy = 1'b1;
    for (int k = 0; k < SIZE - 1; k++) begin
      for (int i = k + 1; i < SIZE; i++) begin
        readRow(k, rowK);
        readRow(i, rowI);
        piv  = elem(rowK, k);
        lval = elem(rowI, k) / piv;
        rowI[k] = {64'b0, $realtobits(lval)};
        for (int j = k + 1; j < SIZE; j++) begin
          rowI[j] = {64'b0, $realtobits(elem(rowI, j) - lval * elem(rowK, j))};
        end
        writeRow(i, rowI);
      end
    end
    for (int i = 0; i < SIZE; i++) begin
      readRow(i, luGot[i]);
      for (int j = 0; j < SIZE; j++) begin
        checkOutput($sformatf("LU r%0d c%0d", i, j), canon(elem(luGot[i], j)),
                    canon(elem(luExp[i], j)));
      end
    end
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < SIZE; j++) begin
        acc = 0.0;
        for (int m = 0; m < SIZE; m++) begin
          lij = (m < i) ? elem(luGot[i], m) : ((m == i) ? 1.0 : 0.0);
          uij = (m <= j) ? elem(luGot[m], j) : 0.0;
          acc = acc + lij * uij;
        end
        checkOutput($sformatf("L*U r%0d c%0d", i, j), canon(acc), canon(elem(matA[i], j)));
      end
    end
    luBusy = 1'b0;
    applyStimulus(1);
    checkOutput("LU loop back to IDLE", loadReady, 1);

    // Flush in RUN outranks a concurrent read and write.
    loadRows(idR[0], idR[1], idR[2], idR[3]);
    applyStimulus(1);
    luBusy = 1'b1;
    readRow(1, rowGot);
    checkOutput("pre-flush read row 1", rowGot, idR[1]);
    flush = 1'b1;
    rdAddrI = 2'd2; rdAddrVld = 1'b1;
    wrAddr = 2'd1; wrRow = zRow; wrValid = 1'b1;
    #1;
    checkOutput("flush wr_ready_o", wrReady, 0);
    applyStimulus(1);
    flush = 1'b0; rdAddrVld = 1'b0; wrValid = 1'b0; luBusy = 1'b0;
    #1;
    checkOutput("flush rd_valid_o", rdValidO, 0);
    checkOutput("flush rd_addr_o held", rdAddrO, 1);
    checkOutput("flush rd_row_o held", rdRowO, idR[1]);
    checkOutput("flush load_ready_o", loadReady, 1);
    checkOutput("flush wr_ready_o after", wrReady, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
